// File: rtl/pcie_sram_arb_pkg.sv
// Shared types and defaults for the PCIe message SRAM port arbiter.
// Optional statistics outputs are enabled with SRAM_ARB_STATS_EN.
package pcie_sram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_WR   = 2'd1,
    OWN_RD   = 2'd2
  } owner_e;

  localparam int DEF_DATA_WIDTH = 256;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_MAX_WAIT   = 15;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v,
    input logic [7:0] lim
  );
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

endpackage

// File: rtl/pcie_sram_arb_core.sv
// Grant, burst-lock and starvation-age decision for the SRAM arbiter.
// Exposes a forced-grant strobe only when SRAM_ARB_STATS_EN is defined.
module pcie_sram_arb_core
  import pcie_sram_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_req,
  input  logic wr_lock,
  input  logic rd_req,
  input  logic rd_lock,
  output logic wr_gnt,
  output logic rd_gnt
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic forced
`endif
);

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  owner_e     owner;
  owner_e     last;
  owner_e     gnt_side;
  logic       locked;
  logic [7:0] wait_cnt;

  logic waiter_wr;
  logic waiter_req;
  logic own_req;
  logic hit_force;
  logic hit_lock;
  logic hit_one;
  logic hit_tie;
  logic pick_wr;
  logic pick_rd;
  logic other_req;
  logic gnt_lock;

  // The side that did not win last is the only one that can be aging.
  assign waiter_wr  = (last == OWN_RD);
  assign waiter_req = waiter_wr ? wr_req : rd_req;
  assign own_req    = ((owner == OWN_WR) && wr_req) ||
                      ((owner == OWN_RD) && rd_req);

  assign hit_force = (wait_cnt == WAIT_LIM) && waiter_req;
  assign hit_lock  = !hit_force && locked && own_req;
  assign hit_one   = !hit_force && !hit_lock && (wr_req ^ rd_req);
  assign hit_tie   = !hit_force && !hit_lock && wr_req && rd_req;

  always_comb begin
    pick_wr = 1'b0;
    pick_rd = 1'b0;
    unique case (1'b1)
      hit_force: begin
        pick_wr = waiter_wr;
        pick_rd = !waiter_wr;
      end
      hit_lock: begin
        pick_wr = (owner == OWN_WR);
        pick_rd = (owner == OWN_RD);
      end
      hit_one: begin
        pick_wr = wr_req;
        pick_rd = rd_req;
      end
      hit_tie: begin
        pick_wr = waiter_wr;
        pick_rd = !waiter_wr;
      end
      default: ;
    endcase
  end

  assign wr_gnt = pick_wr & wr_req & ~rst;
  assign rd_gnt = pick_rd & rd_req & ~rst;

  assign other_req = wr_gnt ? rd_req : wr_req;
  assign gnt_side  = wr_gnt ? OWN_WR : OWN_RD;
  assign gnt_lock  = hit_force ? 1'b0 : (wr_gnt ? wr_lock : rd_lock);

`ifdef SRAM_ARB_STATS_EN
  assign forced = hit_force & ~rst;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= OWN_NONE;
      last     <= OWN_RD;
      locked   <= 1'b0;
      wait_cnt <= 8'd0;
    end else if (wr_gnt | rd_gnt) begin
      owner  <= gnt_side;
      last   <= gnt_side;
      locked <= gnt_lock;
      // A change of owner means the loser starts a fresh wait this cycle.
      if (!other_req)
        wait_cnt <= 8'd0;
      else if (gnt_side == last)
        wait_cnt <= sat_inc(wait_cnt, WAIT_LIM);
      else
        wait_cnt <= 8'd1;
    end else begin
      owner    <= OWN_NONE;
      locked   <= 1'b0;
      wait_cnt <= 8'd0;
    end
  end

endmodule

// File: rtl/pcie_sram_port_arbiter.sv
// Two-port arbiter sharing one single-port message SRAM (writer vs reader).
// Define SRAM_ARB_STATS_EN to add conflict_cnt / force_cnt outputs.
module pcie_sram_port_arbiter
  import pcie_sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic                  wr_lock,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic                  rd_lock,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]           conflict_cnt,
  output logic [15:0]           force_cnt
`endif
);

  logic rd_valid_q;

`ifdef SRAM_ARB_STATS_EN
  logic forced;
`endif

  pcie_sram_arb_core #(
    .MAX_WAIT (MAX_WAIT)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .wr_req  (wr_req),
    .wr_lock (wr_lock),
    .rd_req  (rd_req),
    .rd_lock (rd_lock),
    .wr_gnt  (wr_gnt),
    .rd_gnt  (rd_gnt)
`ifdef SRAM_ARB_STATS_EN
    ,
    .forced  (forced)
`endif
  );

  assign sram_en    = wr_gnt | rd_gnt;
  assign sram_we    = wr_gnt;
  assign sram_addr  = wr_gnt ? wr_addr :
                      rd_gnt ? rd_addr : '0;
  assign sram_wdata = wr_gnt ? wr_data : '0;

  always_ff @(posedge clk) begin
    if (rst)
      rd_valid_q <= 1'b0;
    else
      rd_valid_q <= rd_gnt;
  end

  // A read returning during reset is dropped rather than delivered.
  assign rd_valid = rd_valid_q & ~rst;
  assign rd_data  = rd_valid ? sram_rdata : '0;

`ifdef SRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= 16'd0;
      force_cnt    <= 16'd0;
    end else begin
      if (wr_req && rd_req && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
      if (forced && (force_cnt != 16'hFFFF))
        force_cnt <= force_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcie_sram_port_arbiter.sv
// Scoreboard bench for pcie_sram_port_arbiter with a behavioural SRAM.
// Build with SRAM_ARB_STATS_EN to also check the statistics counters.
module tb_pcie_sram_port_arbiter;

  localparam int DW = 256;
  localparam int AW = 10;

  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } gexp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req, wr_lock, rd_req, rd_lock;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt, rd_gnt, rd_valid;
  logic [DW-1:0] rd_data;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0]   conflict_cnt, force_cnt;
`endif

  int checks = 0;
  int errors = 0;

  gexp_t         gq[$];
  logic [DW-1:0] rq[$];
  logic          prev_rdg = 1'b0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  pcie_sram_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_lock    (wr_lock),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_gnt     (wr_gnt),
    .rd_req     (rd_req),
    .rd_lock    (rd_lock),
    .rd_addr    (rd_addr),
    .rd_gnt     (rd_gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
`ifdef SRAM_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .force_cnt    (force_cnt)
`endif
  );

  // Single-port SRAM, one-cycle read latency.
  always @(posedge clk) begin
    if (sram_en && sram_we)
      mem[sram_addr] <= sram_wdata;
    if (sram_en && !sram_we)
      sram_rdata <= mem[sram_addr];
  end

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  function automatic void push_w(input logic [AW-1:0] a,
                                 input logic [DW-1:0] d);
    gexp_t e;
    e.wr = 1'b1; e.addr = a; e.data = d;
    gq.push_back(e);
  endfunction

  function automatic void push_r(input logic [AW-1:0] a);
    gexp_t e;
    e.wr = 1'b0; e.addr = a; e.data = '0;
    gq.push_back(e);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT shows a grant or a return.
  always @(negedge clk) begin : mon
    gexp_t e;
    chk("rd_valid_timing", rd_valid, prev_rdg && !rst);
    chk("gnt_without_req",
        (wr_gnt && !wr_req) || (rd_gnt && !rd_req), 0);
    if (wr_gnt || rd_gnt) begin
      if (gq.size() == 0) begin
        chk("unexpected_grant", {wr_gnt, rd_gnt}, 0);
      end else begin
        e = gq.pop_front();
        chk("gnt_side", {wr_gnt, rd_gnt}, {e.wr, !e.wr});
        chk("sram_en", sram_en, 1);
        chk("sram_we", sram_we, e.wr);
        chk("sram_addr", sram_addr, e.addr);
        chk("sram_wdata", sram_wdata, e.data);
      end
    end else begin
      chk("idle_en", sram_en, 0);
      chk("idle_addr", sram_addr, 0);
      chk("idle_wdata", sram_wdata, 0);
    end
    if (rd_valid) begin
      if (rq.size() == 0)
        chk("unexpected_rd_valid", rd_valid, 0);
      else
        chk("rd_data", rd_data, rq.pop_front());
    end else begin
      chk("rd_data_idle", rd_data, 0);
    end
    prev_rdg <= rd_gnt;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_req = 0; wr_lock = 0; rd_req = 0; rd_lock = 0;
  endtask

  task automatic burst();
    int wi = 0;
    int ri = 0;
    int n  = 0;
    wr_lock = 1; rd_lock = 0; rd_addr = 10'h010;
    while ((wi < 40 || ri < 3) && n < 80) begin
      wr_req  = (wi < 40);
      wr_addr = 10'h100 + AW'(wi);
      wr_data = DW'(32'hB000_0000 + wi);
      rd_req  = (ri < 3);
      @(negedge clk);
      if (wr_gnt) wi++;
      if (rd_gnt) ri++;
      cyc();
      n++;
    end
    chk("burst_timeout", n >= 80, 0);
    idle_in();
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    sram_rdata = '0;
    rst = 1; idle_in();
    wr_addr = '0; wr_data = '0; rd_addr = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_sram_en", sram_en, 0);
    cyc();
    rst = 0;
    cyc();

    // Write only
    push_w(10'h005, {32{8'hA5}});
    wr_req = 1; wr_addr = 10'h005; wr_data = {32{8'hA5}};
    cyc();
    idle_in();
    cyc();

    // Tie after reset: WR, RD, WR, RD with read-after-write data
    rst = 1;
    cyc();
    rst = 0;
    push_w(10'h021, DW'(32'hD1));
    push_r(10'h021); rq.push_back(DW'(32'hD1));
    push_w(10'h021, DW'(32'hD2));
    push_r(10'h021); rq.push_back(DW'(32'hD2));
    wr_req = 1; rd_req = 1; wr_addr = 10'h021; rd_addr = 10'h021;
    wr_data = DW'(32'hD1);
    cyc();
    wr_data = DW'(32'hD2);
    cyc();
    cyc();
    wr_data = DW'(32'hD3);
    cyc();
    idle_in();
    cyc();

    // Read return
    push_w(10'h010, DW'(16'h1234));
    push_r(10'h010); rq.push_back(DW'(16'h1234));
    wr_req = 1; wr_addr = 10'h010; wr_data = DW'(16'h1234);
    cyc();
    wr_req = 0; rd_req = 1; rd_addr = 10'h010;
    cyc();
    idle_in();
    cyc();

    // Locked write burst with a starving reader
    for (int i = 0; i < 15; i++) push_w(10'h100 + AW'(i), DW'(32'hB000_0000 + i));
    push_r(10'h010); rq.push_back(DW'(16'h1234));
    for (int i = 15; i < 30; i++) push_w(10'h100 + AW'(i), DW'(32'hB000_0000 + i));
    push_r(10'h010); rq.push_back(DW'(16'h1234));
    for (int i = 30; i < 40; i++) push_w(10'h100 + AW'(i), DW'(32'hB000_0000 + i));
    push_r(10'h010); rq.push_back(DW'(16'h1234));
    burst();
`ifdef SRAM_ARB_STATS_EN
    chk("force_cnt", force_cnt, 2);
    chk("conflict_cnt", conflict_cnt, 46);
`endif
    cyc();

    // Lock drop: locked reader goes away, writer gets the same cycle
    push_r(10'h010); rq.push_back(DW'(16'h1234));
    push_w(10'h030, DW'(32'hEEEE));
    push_r(10'h030); rq.push_back(DW'(32'hEEEE));
    rd_req = 1; rd_lock = 1; rd_addr = 10'h010;
    cyc();
    rd_req = 0; rd_lock = 0;
    wr_req = 1; wr_addr = 10'h030; wr_data = DW'(32'hEEEE);
    cyc();
    wr_req = 0; rd_req = 1; rd_addr = 10'h030;
    cyc();
    idle_in();
    cyc();

    // Reset mid-read: in-flight return is dropped
    push_r(10'h030);
    rd_req = 1; rd_addr = 10'h030;
    cyc();
    rd_req = 0; rst = 1;
    @(negedge clk);
    chk("rstmid_rd_valid", rd_valid, 0);
    chk("rstmid_rd_data", rd_data, 0);
    chk("rstmid_gnt", {wr_gnt, rd_gnt}, 0);
    chk("rstmid_sram_en", sram_en, 0);
    cyc();
    rst = 0;
`ifdef SRAM_ARB_STATS_EN
    chk("rst_force_cnt", force_cnt, 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
`endif
    push_w(10'h040, DW'(32'hF00D));
    push_r(10'h040); rq.push_back(DW'(32'hF00D));
    wr_req = 1; wr_addr = 10'h040; wr_data = DW'(32'hF00D);
    rd_req = 1; rd_addr = 10'h040;
    cyc();
    wr_req = 0;
    cyc();
    idle_in();
    repeat (3) cyc();

    chk("grant_queue_drained", gq.size(), 0);
    chk("read_queue_drained", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_sram_port_arbiter.md
Name: pcie_sram_port_arbiter

Overview:
- Shares one single-port 256-bit message SRAM between two requesters:
  - the write requester, i.e. the message receiver/assembler;
  - the read requester, i.e. the AXI-to-SRAM read bridge.
- Sits between both engines and the SRAM macro.
- Provides round-robin arbitration, burst locking, starvation-breaking and 1-cycle read-return tracking.

Parameters:
- DATA_WIDTH, 256, SRAM word width
- ADDR_WIDTH, 10, SRAM word address width
- MAX_WAIT, 15, cycles a requesting loser may wait before forced grant (1..255)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- wr_req  in  1  write requester has a beat pending
- wr_lock  in  1  keep ownership after this beat (burst continues)
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_gnt  out  1  write beat accepted this cycle
- rd_req  in  1  read requester has a beat pending
- rd_lock  in  1  keep ownership after this beat
- rd_addr  in  ADDR_WIDTH  read address
- rd_gnt  out  1  read beat accepted this cycle
- rd_valid  out  1  rd_data valid (one cycle after rd_gnt)
- rd_data  out  DATA_WIDTH  returned read data
- sram_en  out  1  SRAM access enable
- sram_we  out  1  1 = write, 0 = read
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data, 1-cycle latency after read enable

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Handshake:
  - Each requester holds its req, addr and data stable until it sees gnt.
  - A beat transfers in the cycle where req && gnt.
  - gnt is combinational from req plus registered arbiter state; at most one gnt per cycle.
  - gnt is never asserted without the matching req.
- SRAM drive:
  - sram_en = wr_gnt | rd_gnt.
  - sram_we = wr_gnt.
  - sram_addr and sram_wdata are muxed from the granted requester.
  - When idle, sram_addr and sram_wdata are 0.
- Registered state:
  - owner: NONE, WR or RD.
  - locked: 1 bit.
  - last: last granted requester, WR or RD; reset to RD, so write wins the first tie.
  - wait_cnt: 8 bits.
- Grant decision, in priority order:
  1. If wait_cnt == MAX_WAIT and the waiting side requests, grant the waiting side. Lock is broken and locked is cleared.
  2. Else if locked and the owner requests, grant the owner.
  3. Else if exactly one side requests, grant it.
  4. Else if both request, grant the side that is not last.
- Lock rules:
  - On a transfer, locked <= lock input of the granted side; owner <= granted side; last <= granted side.
  - If locked but the owner drops req, locked clears and ownership is free that cycle (rule 3 or 4 applies).
- wait_cnt:
  - Increments, saturating at MAX_WAIT, on each cycle the non-granted side has req=1 and another side holds the grant.
  - Clears when the waiting side is granted or drops req.
- Read return:
  - rd_valid is a 1-cycle delayed copy of rd_gnt.
  - rd_data = sram_rdata when rd_valid, else 0.
  - Back-to-back reads give one rd_valid per cycle with no bubbles.
- Simultaneous events:
  - A write granted the cycle after a read does not disturb that read's return; the SRAM guarantees the read output.
  - Read-after-write to the same address in consecutive cycles returns the new data, since access is serialized.
- Reset mid-operation:
  - Reset values: owner=NONE, locked=0, last=RD, wait_cnt=0, rd_valid=0; all outputs 0.
  - A read in flight is discarded; rd_valid is 0 the cycle after reset.

Optional Feature:
- Macro SRAM_ARB_STATS_EN.
- When defined, adds these outputs:
  - conflict_cnt [15:0]: cycles with wr_req && rd_req.
  - force_cnt [15:0]: starvation-forced grants.
- Both counters saturate at 16'hFFFF and clear on rst.
- When undefined, these ports and their logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared package pcie_sram_arb_pkg holds:
  - the owner enum (NONE=2'd0, WR=2'd1, RD=2'd2);
  - default DATA_WIDTH and ADDR_WIDTH constants;
  - MAX_WAIT default.
- One sub-module, pcie_sram_arb_core: purely the grant/lock/age decision plus its state registers.
- The top module adds the SRAM mux, the read-return pipeline and the stats.

Test Plan:
- Write only: wr_req held with addr 0x005 and data 0xA5.., no rd_req. Expect wr_gnt the same cycle, sram_en=1, sram_we=1, sram_addr=0x005.
- Tie after reset: both requesters request with lock=0. Expect the grant sequence WR, RD, WR, RD on alternating cycles.
- Read return: write 0x1234 to address 0x010, then read address 0x010. Expect rd_valid exactly one cycle after rd_gnt, with rd_data=0x1234.
- Write burst lock: wr_lock=1 for 40 beats while rd_req is held. Expect rd_gnt forced when wait_cnt reaches 15 (16th waiting cycle), then a write re-grant. With SRAM_ARB_STATS_EN defined, force_cnt increments per forced grant.
- Lock drop: owner drops req while locked and the other side requests. Expect a grant to the other side the same cycle and locked cleared.
- Reset mid-read: assert rst the cycle after rd_gnt. Expect rd_valid=0, all outputs 0, and a write winning the next tie.
